mult_unit: RTL and testbench

- Iterative 32x32 multiplier for the pipelined MIPS datapath: executes MULT/MULTU, owns the HI/LO registers, and serves MFHI/MFLO/MTHI/MTLO.
- Responder side of the hazard unit's multiply handshake: consumes multstartE from the Execute stage and returns pve (product valid), which the hazard logic uses to hold the pipeline stalled until the product is ready.
- Fixed, data-independent latency.

---
 rtl/mult_if.sv | 26 ++
 rtl/mult_unit.sv | 102 ++++++++++
 tb/tb_mult_unit.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/mult_if.sv
// Multiply handshake and HI/LO access between the Execute stage / hazard unit and mult_unit.
interface mult_if #(
    parameter int WIDTH = 32
);
    logic             multstartE;
    logic             signedE;
    logic [WIDTH-1:0] srcaE;
    logic [WIDTH-1:0] srcbE;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             pve;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output multstartE, signedE, srcaE, srcbE, hi_we, lo_we, wdata,
        input  pve, busy, hi, lo
    );

    modport slave (
        input  multstartE, signedE, srcaE, srcbE, hi_we, lo_we, wdata,
        output pve, busy, hi, lo
    );
endinterface

// File: rtl/mult_unit.sv
// Iterative shift-add multiplier owning HI/LO for MULT/MULTU/MFHI/MFLO/MTHI/MTLO.
// Works on operand magnitudes; sign is reapplied to the full product at completion.
module mult_unit #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input logic   clk,
    input logic   reset_n,
    mult_if.slave bus
);
    localparam int ITER  = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state;
    state_t             stateNext;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] partial;
    logic [2*WIDTH-1:0] sum;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   hiReg;
    logic [WIDTH-1:0]   loReg;
    logic [CNT_W-1:0]   count;
    logic               neg;
    logic               accept;
    logic               lastStep;

    // Unsigned result, so the most negative input maps to 2^(WIDTH-1) without overflow.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic isSigned);
        return (isSigned && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] negateIf(input logic [2*WIDTH-1:0] p, input logic n);
        return n ? (~p + (2*WIDTH)'(1)) : p;
    endfunction

    always_comb begin
        accept   = (state != RUN) && bus.multstartE;
        lastStep = (state == RUN) && (count == CNT_W'(ITER - 1));
    end

    always_comb begin
        partial = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mplier[i]) partial = partial + (mcand << i);
        end
        sum = acc + partial;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE, DONE: if (bus.multstartE) stateNext = RUN;
            RUN:        if (lastStep)       stateNext = DONE;
            default:    stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            neg    <= 1'b0;
            count  <= '0;
            hiReg  <= '0;
            loReg  <= '0;
        end else if (accept) begin
            // A start on the same edge as an MT write wins; the write is dropped.
            mcand  <= {{WIDTH{1'b0}}, magnitude(bus.srcaE, bus.signedE)};
            mplier <= magnitude(bus.srcbE, bus.signedE);
            neg    <= bus.signedE & (bus.srcaE[WIDTH-1] ^ bus.srcbE[WIDTH-1]);
            acc    <= '0;
            count  <= '0;
        end else if (state == RUN) begin
            acc    <= sum;
            mcand  <= mcand << BITS_PER_CYCLE;
            mplier <= mplier >> BITS_PER_CYCLE;
            count  <= count + CNT_W'(1);
            if (lastStep) {hiReg, loReg} <= negateIf(sum, neg);
        end else begin
            if (bus.hi_we) hiReg <= bus.wdata;
            if (bus.lo_we) loReg <= bus.wdata;
        end
    end

    assign bus.pve  = (state == DONE);
    assign bus.busy = (state == RUN);
    assign bus.hi   = hiReg;
    assign bus.lo   = loReg;
endmodule

// File: tb/tb_mult_unit.sv
// Self-checking bench for mult_unit against a plain-arithmetic 64-bit product model.
module tb_mult_unit;
    localparam int WIDTH = 32;
    localparam int BPC   = 1;
    localparam int ITER  = WIDTH / BPC;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    mult_if #(.WIDTH(WIDTH)) bus ();

    mult_unit #(.WIDTH(WIDTH), .BITS_PER_CYCLE(BPC)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int          nChecks = 0;
    int          nFail   = 0;
    logic [31:0] expHi   = '0;
    logic [31:0] expLo   = '0;
    logic        expPve  = 1'b0;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] refProduct(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            return sa * sb;
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkIdle(input string tag);
        checkVal({tag, ".busyPve"}, {62'b0, bus.busy, bus.pve}, {62'b0, 1'b0, expPve});
        checkVal({tag, ".hilo"}, {bus.hi, bus.lo}, {expHi, expLo});
    endtask

    // extraStartCyc / weCyc: cycle offset after the start edge at which to inject a
    // spurious start or MT write (-1 = none); weAtStart drives MT writes with the start.
    task automatic runMult(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input int extraStartCyc, input int weCyc, input bit weAtStart);
        logic [63:0] prod;
        bus.srcaE      = a;
        bus.srcbE      = b;
        bus.signedE    = s;
        bus.multstartE = 1'b1;
        bus.hi_we      = weAtStart;
        bus.lo_we      = weAtStart;
        bus.wdata      = 32'h5A5A_A5A5;
        step();
        bus.multstartE = 1'b0;
        bus.hi_we      = 1'b0;
        bus.lo_we      = 1'b0;
        bus.srcaE      = $urandom;
        bus.srcbE      = $urandom;
        bus.signedE    = $urandom_range(0, 1);
        checkVal("start.busyPve", {62'b0, bus.busy, bus.pve}, 64'h2);
        for (int cyc = 1; cyc <= ITER; cyc++) begin
            if (cyc == extraStartCyc) begin
                bus.multstartE = 1'b1;
                bus.srcaE      = 32'd9;
                bus.srcbE      = 32'd9;
            end
            if (cyc == weCyc) begin
                bus.hi_we = 1'b1;
                bus.lo_we = 1'b1;
                bus.wdata = 32'hCAFE_F00D;
            end
            step();
            bus.multstartE = 1'b0;
            bus.hi_we      = 1'b0;
            bus.lo_we      = 1'b0;
            if (cyc < ITER) begin
                checkVal("run.busyPve", {62'b0, bus.busy, bus.pve}, 64'h2);
                checkVal("run.hilo", {bus.hi, bus.lo}, {expHi, expLo});
            end
        end
        prod   = refProduct(a, b, s);
        expHi  = prod[63:32];
        expLo  = prod[31:0];
        expPve = 1'b1;
        checkIdle("done");
    endtask

    initial begin
        bus.multstartE = 1'b0;
        bus.signedE    = 1'b0;
        bus.srcaE      = '0;
        bus.srcbE      = '0;
        bus.hi_we      = 1'b0;
        bus.lo_we      = 1'b0;
        bus.wdata      = '0;
        step();
        step();
        checkIdle("reset");
        reset_n = 1'b1;
        step();
        checkIdle("postReset");

        runMult(32'd3, 32'd5, 1'b0, -1, -1, 1'b0);
        checkVal("multu3x5", {bus.hi, bus.lo}, 64'h0000_0000_0000_000F);
        runMult(32'hFFFF_FFF9, 32'd6, 1'b1, -1, -1, 1'b0);
        checkVal("multNeg7x6", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFD6);
        runMult(32'h8000_0000, 32'h8000_0000, 1'b1, -1, -1, 1'b0);
        checkVal("multMinMin", {bus.hi, bus.lo}, 64'h4000_0000_0000_0000);
        runMult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1, -1, 1'b0);
        checkVal("multuMaxMax", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
        runMult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, -1, -1, 1'b0);
        checkVal("multNeg1Neg1", {bus.hi, bus.lo}, 64'h0000_0000_0000_0001);
        runMult(32'h8000_0000, 32'h0000_0001, 1'b1, -1, -1, 1'b0);
        runMult(32'h0, 32'h1234_5678, 1'b1, -1, -1, 1'b0);

        // Start during RUN is dropped; pve holds afterwards.
        runMult(32'd2, 32'd2, 1'b0, 5, -1, 1'b0);
        checkVal("ignoredStart.lo", {32'b0, bus.lo}, 64'd4);
        repeat (4) begin
            step();
            checkIdle("holdDone");
        end

        bus.hi_we = 1'b1;
        bus.wdata = 32'hDEAD_BEEF;
        step();
        bus.hi_we = 1'b0;
        expHi     = 32'hDEAD_BEEF;
        checkIdle("mthi");
        bus.lo_we = 1'b1;
        bus.wdata = 32'h0BAD_F00D;
        step();
        bus.lo_we = 1'b0;
        expLo     = 32'h0BAD_F00D;
        checkIdle("mtlo");

        runMult(32'd7, 32'd11, 1'b0, -1, 3, 1'b0);
        runMult(32'hFFFF_0001, 32'h0000_FFFF, 1'b1, -1, -1, 1'b1);

        for (int n = 0; n < 24; n++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
            if ($urandom_range(0, 5) == 0) b = $urandom_range(0, 1) ? 32'h0 : 32'hFFFF_FFFF;
            runMult(a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 1) ? int'($urandom_range(1, ITER - 1)) : -1,
                    $urandom_range(0, 1) ? int'($urandom_range(1, ITER - 1)) : -1, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) begin
                bus.hi_we = 1'($urandom_range(0, 1));
                bus.lo_we = 1'($urandom_range(0, 1));
                bus.wdata = $urandom;
                step();
                if (bus.hi_we) expHi = bus.wdata;
                if (bus.lo_we) expLo = bus.wdata;
                bus.hi_we = 1'b0;
                bus.lo_we = 1'b0;
                checkIdle("randMt");
            end
        end

        // Asynchronous reset in the middle of a run.
        bus.srcaE      = 32'd4;
        bus.srcbE      = 32'd4;
        bus.signedE    = 1'b0;
        bus.multstartE = 1'b1;
        step();
        bus.multstartE = 1'b0;
        repeat (9) step();
        #2;
        reset_n = 1'b0;
        #1;
        expHi  = '0;
        expLo  = '0;
        expPve = 1'b0;
        checkIdle("asyncReset");
        step();
        step();
        checkIdle("resetHeld");
        reset_n = 1'b1;
        step();
        runMult(32'd1, 32'd1, 1'b0, -1, -1, 1'b0);
        checkVal("afterReset.lo", {32'b0, bus.lo}, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
